// File: rtl/demo_01_pkg.sv
// ============================================================================
// Module      : demo_01_pkg
// Description : Shared constants and helpers for the five-input majority voter
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package demo_01_pkg;

    localparam int NUM_VOTERS     = 5;
    localparam int CNT_W          = 3;
    localparam int DEFAULT_THRESH = 3;

    // A decision is unanimous when nobody or everybody voted yes
    function automatic logic is_unanimous(input logic [CNT_W-1:0] cnt);
        return (cnt == '0) || (cnt == CNT_W'(NUM_VOTERS));
    endfunction

endpackage

`default_nettype wire

// File: rtl/demo_01_popcount5.sv
// ============================================================================
// Module      : popcount5
// Description : Combinational yes-vote counter for five voters
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module popcount5
    import demo_01_pkg::*;
(
    input  logic [NUM_VOTERS-1:0] i_votes,
    output logic [CNT_W-1:0]      o_count
);

    // Sum of all set bits; five voters never exceed the 3-bit range
    always_comb begin
        o_count = '0;
        for (int i = 0; i < NUM_VOTERS; i++) begin
            o_count = o_count + {{(CNT_W-1){1'b0}}, i_votes[i]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/demo_01.sv
// ============================================================================
// Module      : demo_01
// Description : Five-input majority voter with registered result, yes count
//               and unanimity flag (one cycle latency, async reset)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demo_01
    import demo_01_pkg::*;
#(
    parameter int THRESH = DEFAULT_THRESH
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             D,
    input  logic             E,
    output logic             F,
    output logic [CNT_W-1:0] COUNT,
    output logic             UNANIMOUS
);

    // A threshold outside 1..5 would make the voter constant; reject it early
    if ((THRESH < 1) || (THRESH > NUM_VOTERS)) begin : g_thresh_check
        $error("demo_01: THRESH=%0d outside legal range 1..%0d", THRESH, NUM_VOTERS);
    end

    localparam logic [CNT_W-1:0] c_thresh = CNT_W'(THRESH);

    logic [NUM_VOTERS-1:0] w_votes;
    logic [CNT_W-1:0]      w_count;
    logic                  w_f_next;
    logic                  w_unanimous_next;

    logic                  r_f;
    logic [CNT_W-1:0]      r_count;
    logic                  r_unanimous;

    // A is voter 0; bit order is irrelevant to the count but kept stable
    assign w_votes = {E, D, C, B, A};

    popcount5 u_popcount5 (
        .i_votes (w_votes),
        .o_count (w_count)
    );

    // Next-state decision derived from the same count so all outputs agree
    always_comb begin
        w_f_next         = (w_count >= c_thresh);
        w_unanimous_next = is_unanimous(w_count);
    end

    // Output registers; reset forces UNANIMOUS low even though count is 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f         <= 1'b0;
            r_count     <= '0;
            r_unanimous <= 1'b0;
        end else begin
            r_f         <= w_f_next;
            r_count     <= w_count;
            r_unanimous <= w_unanimous_next;
        end
    end

    assign F         = r_f;
    assign COUNT     = r_count;
    assign UNANIMOUS = r_unanimous;

endmodule

`default_nettype wire

// File: tb/tb_demo_01.sv
// ============================================================================
// Module      : tb_demo_01
// Description : Self-checking bench for demo_01, one instance per THRESH 1..5
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demo_01;

    logic       clk;
    logic       rst;
    logic [4:0] r_votes;      // {A,B,C,D,E}: bit 4 is A, bit 0 is E

    logic       w_f     [1:5];
    logic [2:0] w_count [1:5];
    logic       w_unan  [1:5];

    int n_cmp;
    int n_err;

    for (genvar t = 1; t <= 5; t++) begin : g_dut
        demo_01 #(.THRESH(t)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .A         (r_votes[4]),
            .B         (r_votes[3]),
            .C         (r_votes[2]),
            .D         (r_votes[1]),
            .E         (r_votes[0]),
            .F         (w_f[t]),
            .COUNT     (w_count[t]),
            .UNANIMOUS (w_unan[t])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: yes votes counted arithmetically, returns {F,COUNT,UNANIMOUS}
    function automatic logic [4:0] model(input int th, input logic [4:0] v);
        int yes;
        yes = 0;
        for (int i = 0; i < 5; i++) if (v[i]) yes = yes + 1;
        return {(yes >= th), 3'(yes), (yes == 0 || yes == 5)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        r_votes = 5'b00000;
        rst     = 1'b0;
        tick();
        r_votes = 5'b11111;
        tick();
        #3;
        rst = 1'b1;
        #1;
        for (int t = 1; t <= 5; t++) begin
            n_cmp++;
            if ({w_f[t], w_count[t], w_unan[t]} !== 5'b0_000_0) begin
                n_err++;
                $display("FAIL reset_async th=%0d: got F=%0b COUNT=%0d UNAN=%0b want F=0 COUNT=0 UNAN=0",
                         t, w_f[t], w_count[t], w_unan[t]);
            end
        end
        tick();
        n_cmp++;
        if ({w_f[3], w_count[3], w_unan[3]} !== 5'b0_000_0) begin
            n_err++;
            $display("FAIL reset_held: got F=%0b COUNT=%0d UNAN=%0b want 0/0/0",
                     w_f[3], w_count[3], w_unan[3]);
        end
        #2;
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({w_f[3], w_count[3], w_unan[3]} !== 5'b1_101_1) begin
            n_err++;
            $display("FAIL reset_release: got F=%0b COUNT=%0d UNAN=%0b want F=1 COUNT=5 UNAN=1",
                     w_f[3], w_count[3], w_unan[3]);
        end
    endtask

    task automatic test_sweep();
        logic [4:0] pats   [6] = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111};
        logic       exp_f  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [2:0] exp_c  [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        logic       exp_u  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            r_votes = pats[i];
            tick();
            n_cmp++;
            if ({w_f[3], w_count[3], w_unan[3]} !== {exp_f[i], exp_c[i], exp_u[i]}) begin
                n_err++;
                $display("FAIL sweep votes=%05b: got F=%0b COUNT=%0d UNAN=%0b want F=%0b COUNT=%0d UNAN=%0b",
                         pats[i], w_f[3], w_count[3], w_unan[3], exp_f[i], exp_c[i], exp_u[i]);
            end
        end
    endtask

    task automatic test_mixed();
        logic [4:0] pats  [5] = '{5'b01010, 5'b10101, 5'b10000, 5'b11000, 5'b11100};
        logic       exp_f [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0] exp_c [5] = '{3'd2, 3'd3, 3'd1, 3'd2, 3'd3};
        for (int i = 0; i < 5; i++) begin
            r_votes = pats[i];
            tick();
            n_cmp++;
            if ({w_f[3], w_count[3]} !== {exp_f[i], exp_c[i]}) begin
                n_err++;
                $display("FAIL mixed votes=%05b: got F=%0b COUNT=%0d want F=%0b COUNT=%0d",
                         pats[i], w_f[3], w_count[3], exp_f[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_unanimity();
        r_votes = 5'b00000;
        tick();
        n_cmp++;
        if ({w_unan[3], w_f[3]} !== 2'b10) begin
            n_err++;
            $display("FAIL unan_none: got UNAN=%0b F=%0b want UNAN=1 F=0", w_unan[3], w_f[3]);
        end
        r_votes = 5'b11110;
        tick();
        n_cmp++;
        if ({w_unan[3], w_f[3]} !== 2'b01) begin
            n_err++;
            $display("FAIL unan_four: got UNAN=%0b F=%0b want UNAN=0 F=1", w_unan[3], w_f[3]);
        end
    endtask

    task automatic test_thresh_sweep();
        r_votes = 5'b00001;
        tick();
        n_cmp++;
        if (w_f[1] !== 1'b1) begin
            n_err++;
            $display("FAIL th1_one_vote: got F=%0b want F=1", w_f[1]);
        end
        r_votes = 5'b11110;
        tick();
        n_cmp++;
        if (w_f[5] !== 1'b0) begin
            n_err++;
            $display("FAIL th5_four_votes: got F=%0b want F=0", w_f[5]);
        end
        r_votes = 5'b11111;
        tick();
        n_cmp++;
        if (w_f[5] !== 1'b1) begin
            n_err++;
            $display("FAIL th5_five_votes: got F=%0b want F=1", w_f[5]);
        end
    endtask

    // All 32 patterns in shuffled order on every THRESH, with a reset pulse midway
    task automatic test_exhaustive();
        logic [4:0] order [32];
        logic [4:0] tmp;
        logic [4:0] want;
        int         j;
        for (int i = 0; i < 32; i++) order[i] = 5'(i);
        for (int i = 31; i > 0; i--) begin
            j        = int'($urandom_range(i, 0));
            tmp      = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int i = 0; i < 32; i++) begin
            if (i == 16) begin
                #2;
                rst = 1'b1;
                #1;
                n_cmp++;
                if ({w_f[2], w_count[2], w_unan[2]} !== 5'b0_000_0) begin
                    n_err++;
                    $display("FAIL midreset: got F=%0b COUNT=%0d UNAN=%0b want 0/0/0",
                             w_f[2], w_count[2], w_unan[2]);
                end
                #1;
                rst = 1'b0;
            end
            r_votes = order[i];
            tick();
            for (int t = 1; t <= 5; t++) begin
                want = model(t, order[i]);
                n_cmp++;
                if ({w_f[t], w_count[t], w_unan[t]} !== want) begin
                    n_err++;
                    $display("FAIL exhaustive th=%0d votes=%05b: got F=%0b COUNT=%0d UNAN=%0b want F=%0b COUNT=%0d UNAN=%0b",
                             t, order[i], w_f[t], w_count[t], w_unan[t], want[4], want[3:1], want[0]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] v;
        logic [4:0] want;
        for (int i = 0; i < 200; i++) begin
            v       = 5'($urandom);
            r_votes = v;
            tick();
            for (int t = 1; t <= 5; t++) begin
                want = model(t, v);
                n_cmp++;
                if ({w_f[t], w_count[t], w_unan[t]} !== want) begin
                    n_err++;
                    $display("FAIL back_to_back th=%0d votes=%05b: got F=%0b COUNT=%0d UNAN=%0b want F=%0b COUNT=%0d UNAN=%0b",
                             t, v, w_f[t], w_count[t], w_unan[t], want[4], want[3:1], want[0]);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b1;
        r_votes = 5'b00000;
        #12;
        test_reset();
        test_sweep();
        test_mixed();
        test_unanimity();
        test_thresh_sweep();
        test_exhaustive();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
